// File: rtl/vga_line_buffer.sv
// vga_line_buffer: ping-pong scan-line buffer in front of the VGA colour output.
// A producer writes one line of pixels over a valid/ready handshake while the
// display side reads the other bank, one pixel per pixelEn.
//
// Optional feature macro: LINE_BUFFER_STATS_EN (adds underrunCount / lineCount).
//
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   wrValid/wrReady  write handshake; wrColor pixel, wrLast closes the line
//   lineStart        start of a display line (bank swap / underrun decision)
//   pixelEn          one displayed pixel; pixColor updates on the next edge
//   pixColor         registered colour to the VGA output
//   underrun         one-cycle pulse when lineStart finds no complete line
//   underrunCount    (stats) saturating underrun counter
//   lineCount        (stats) wrapping successful-swap counter
module vga_line_buffer #(
  parameter int unsigned LINE_PIXELS = 640,
  parameter int unsigned COLOR_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wrValid,
  output logic                   wrReady,
  input  logic [COLOR_WIDTH-1:0] wrColor,
  input  logic                   wrLast,
  input  logic                   lineStart,
  input  logic                   pixelEn,
  output logic [COLOR_WIDTH-1:0] pixColor,
`ifdef LINE_BUFFER_STATS_EN
  output logic [15:0]            underrunCount,
  output logic [15:0]            lineCount,
`endif
  output logic                   underrun
);

  localparam int unsigned PTR_W = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int unsigned LEN_W = $clog2(LINE_PIXELS + 1);

  typedef enum logic {WR_FILL, WR_WAIT} wr_state_e;
  typedef enum logic [1:0] {RD_IDLE, RD_ACTIVE, RD_BLANK} rd_state_e;

  wr_state_e                   wr_state_q, wr_state_d;
  logic                        wr_bank_q, wr_bank_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic                        wr_ready_q, wr_ready_d;
  logic [1:0]                  full_q, full_d;
  logic [1:0][LEN_W-1:0]       len_q, len_d;

  rd_state_e                   rd_state_q, rd_state_d;
  logic                        rd_bank_q, rd_bank_d;
  logic [LEN_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [COLOR_WIDTH-1:0]      pix_color_q, pix_color_d;
  logic                        underrun_q, underrun_d;

  logic [COLOR_WIDTH-1:0]      mem_q [2][LINE_PIXELS];
  logic                        mem_we_c;
  logic                        wr_fire_c;
  logic                        rd_cand_c;

  assign wrReady  = wr_ready_q;
  assign pixColor = pix_color_q;
  assign underrun = underrun_q;

  assign wr_fire_c = wrValid & wr_ready_q;

  // Bank to display next: the one not being read; with no read bank held, the
  // oldest complete line (the WAIT bank if the writer is stalled).
  assign rd_cand_c = (rd_state_q == RD_ACTIVE) ? ~rd_bank_q :
                     ((wr_state_q == WR_WAIT) ? wr_bank_q : ~wr_bank_q);

  // Next-state logic for both sides; release is computed before the write side
  // so a bank freed this cycle is visible to the WAIT/FILL decision.
  always_comb begin
    wr_state_d  = wr_state_q;
    wr_bank_d   = wr_bank_q;
    wr_ptr_d    = wr_ptr_q;
    full_d      = full_q;
    len_d       = len_q;
    rd_state_d  = rd_state_q;
    rd_bank_d   = rd_bank_q;
    rd_ptr_d    = rd_ptr_q;
    pix_color_d = pix_color_q;
    underrun_d  = 1'b0;
    mem_we_c    = 1'b0;

    // Read side: lineStart has priority over pixelEn.
    if (lineStart) begin
      if (rd_state_q == RD_ACTIVE) begin
        full_d[rd_bank_q] = 1'b0;
      end
      // full_q (not full_d): a line closing this cycle is not yet eligible.
      if (full_q[rd_cand_c]) begin
        rd_bank_d  = rd_cand_c;
        rd_ptr_d   = '0;
        rd_state_d = RD_ACTIVE;
      end else begin
        underrun_d = 1'b1;
        rd_state_d = RD_BLANK;
      end
    end else if (pixelEn) begin
      if ((rd_state_q == RD_ACTIVE) && (rd_ptr_q < len_q[rd_bank_q])) begin
        pix_color_d = mem_q[rd_bank_q][PTR_W'(rd_ptr_q)];
        rd_ptr_d    = rd_ptr_q + LEN_W'(1);
      end else begin
        pix_color_d = '0;
      end
    end

    // Write side.
    case (wr_state_q)
      WR_FILL: begin
        if (wr_fire_c) begin
          mem_we_c = 1'b1;
          if (wrLast || (wr_ptr_q == PTR_W'(LINE_PIXELS - 1))) begin
            len_d[wr_bank_q]  = LEN_W'(wr_ptr_q) + LEN_W'(1);
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            wr_ptr_d          = '0;
            if (full_d[~wr_bank_q]) begin
              wr_state_d = WR_WAIT;
            end
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
        end
      end
      WR_WAIT: begin
        if (!full_d[wr_bank_q]) begin
          wr_state_d = WR_FILL;
        end
      end
      default: wr_state_d = WR_FILL;
    endcase

    wr_ready_d = (wr_state_d == WR_FILL);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q  <= WR_FILL;
      wr_bank_q   <= 1'b0;
      wr_ptr_q    <= '0;
      wr_ready_q  <= 1'b0;
      full_q      <= '0;
      len_q       <= '0;
      rd_state_q  <= RD_IDLE;
      rd_bank_q   <= 1'b0;
      rd_ptr_q    <= '0;
      pix_color_q <= '0;
      underrun_q  <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      wr_bank_q   <= wr_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_ready_q  <= wr_ready_d;
      full_q      <= full_d;
      len_q       <= len_d;
      rd_state_q  <= rd_state_d;
      rd_bank_q   <= rd_bank_d;
      rd_ptr_q    <= rd_ptr_d;
      pix_color_q <= pix_color_d;
      underrun_q  <= underrun_d;
    end
  end

  // Line storage; contents need no reset since the full flags gate all reads.
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) begin
      mem_q[wr_bank_q][wr_ptr_q] <= wrColor;
    end
  end

`ifdef LINE_BUFFER_STATS_EN
  logic        line_swap_c;
  logic [15:0] underrun_cnt_q;
  logic [15:0] line_cnt_q;

  assign line_swap_c   = lineStart & full_q[rd_cand_c];
  assign underrunCount = underrun_cnt_q;
  assign lineCount     = line_cnt_q;

  // Statistics: saturating underrun count, wrapping swap count.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_cnt_q <= '0;
      line_cnt_q     <= '0;
    end else begin
      if (underrun_d && (underrun_cnt_q != 16'hFFFF)) begin
        underrun_cnt_q <= underrun_cnt_q + 16'd1;
      end
      if (line_swap_c) begin
        line_cnt_q <= line_cnt_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_line_buffer.sv
// tb_vga_line_buffer: directed stimulus for vga_line_buffer. Expected pixel
// colours and underrun values are queued as stimulus is issued; a monitor
// compares them one cycle after each pixelEn / lineStart.
module tb_vga_line_buffer;

  localparam int unsigned LP = 640;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wrValid;
  logic          wrReady;
  logic [CW-1:0] wrColor;
  logic          wrLast;
  logic          lineStart;
  logic          pixelEn;
  logic [CW-1:0] pixColor;
  logic          underrun;
`ifdef LINE_BUFFER_STATS_EN
  logic [15:0]   underrunCount;
  logic [15:0]   lineCount;
`endif

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] exp_pix_q[$];
  logic          exp_ur_q[$];
  logic          pe_q = 1'b0;
  logic          ls_q = 1'b0;
  logic [CW-1:0] mon_pix;
  logic          mon_ur;

  always #5 clk = ~clk;

  vga_line_buffer #(.LINE_PIXELS(LP), .COLOR_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .wrValid      (wrValid),
    .wrReady      (wrReady),
    .wrColor      (wrColor),
    .wrLast       (wrLast),
    .lineStart    (lineStart),
    .pixelEn      (pixelEn),
    .pixColor     (pixColor),
`ifdef LINE_BUFFER_STATS_EN
    .underrunCount(underrunCount),
    .lineCount    (lineCount),
`endif
    .underrun     (underrun)
  );

  // Monitor: note which edges should produce an output.
  always @(posedge clk) begin
    pe_q <= pixelEn & ~lineStart & ~rst;
    ls_q <= lineStart & ~rst;
  end

  // Monitor: pop and compare on the opposite edge.
  always @(negedge clk) begin
    if (pe_q) begin
      checks++;
      if (exp_pix_q.size() == 0) begin
        errors++;
        $display("FAIL pix_unexpected: got %0d, required no output", pixColor);
      end else begin
        mon_pix = exp_pix_q.pop_front();
        if (pixColor !== mon_pix) begin
          errors++;
          $display("FAIL pixColor: got %0d, required %0d (t=%0t)", pixColor, mon_pix, $time);
        end
      end
    end
    if (ls_q) begin
      checks++;
      if (exp_ur_q.size() == 0) begin
        errors++;
        $display("FAIL ur_unexpected: got %0d, required no output", underrun);
      end else begin
        mon_ur = exp_ur_q.pop_front();
        if (underrun !== mon_ur) begin
          errors++;
          $display("FAIL underrun: got %0d, required %0d (t=%0t)", underrun, mon_ur, $time);
        end
      end
    end else if (underrun !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL underrun_spurious: got %0d, required 0 (t=%0t)", underrun, $time);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset sequence with reset-value and wrReady-rise checks.
  task automatic do_reset();
    rst = 1'b1; wrValid = 1'b0; wrLast = 1'b0; wrColor = '0;
    lineStart = 1'b0; pixelEn = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_pixColor", int'(pixColor), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_wrReady", int'(wrReady), 0);
`ifdef LINE_BUFFER_STATS_EN
    chk("rst_underrunCount", int'(underrunCount), 0);
    chk("rst_lineCount", int'(lineCount), 0);
`endif
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_wrReady_low", int'(wrReady), 0);
    step();
    @(negedge clk);
    chk("wrReady_rise", int'(wrReady), 1);
    step();
  endtask

  task automatic write_px(input logic [CW-1:0] c, input logic last);
    int t = 0;
    wrValid = 1'b1; wrColor = c; wrLast = last;
    @(negedge clk);
    while (!wrReady && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!wrReady) begin
      checks++;
      errors++;
      $display("FAIL wr_timeout: wrReady got 0, required 1");
    end
    @(posedge clk);
    #1;
    wrValid = 1'b0; wrLast = 1'b0;
  endtask

  task automatic write_line(input int n, input bit idx_mode, input logic [CW-1:0] col,
                            input bit use_last);
    for (int i = 0; i < n; i++) begin
      write_px(idx_mode ? CW'(i) : col, use_last && (i == n - 1));
    end
  endtask

  task automatic pix(input logic [CW-1:0] e);
    exp_pix_q.push_back(e);
    pixelEn = 1'b1;
    step();
    pixelEn = 1'b0;
    step();
  endtask

  task automatic line_start(input logic exp_ur, input logic with_pe);
    exp_ur_q.push_back(exp_ur);
    lineStart = 1'b1; pixelEn = with_pe;
    step();
    lineStart = 1'b0; pixelEn = 1'b0;
    step();
  endtask

  initial begin
    // Reset, then a line with nothing written: underrun, all black.
    do_reset();
    line_start(1'b1, 1'b0);
    for (int i = 0; i < int'(LP); i++) pix('0);

    // Full line closed by the pointer limit; extra pixelEn pulses give black.
    write_line(LP, 1'b1, '0, 1'b0);
    line_start(1'b0, 1'b0);
    for (int i = 0; i < int'(LP); i++) pix(CW'(i));
    pix('0);
    pix('0);

    // Short line via wrLast; lineStart with pixelEn ignores the pixelEn.
    write_line(5, 1'b0, 3'b110, 1'b1);
    @(negedge clk);
    chk("wait_wrReady_low", int'(wrReady), 0);
    step();
    line_start(1'b0, 1'b1);
    @(negedge clk);
    chk("resume_wrReady", int'(wrReady), 1);
    step();
    for (int i = 0; i < 8; i++) pix((i < 5) ? 3'b110 : 3'b000);

    // Three lines without lineStart: writer stalls until bank 0 is released.
    do_reset();
    write_line(LP, 1'b0, 3'd1, 1'b0);
    write_line(LP, 1'b0, 3'd2, 1'b0);
    @(negedge clk);
    chk("stall_after_line2", int'(wrReady), 0);
    step();
    line_start(1'b0, 1'b0);
    @(negedge clk);
    chk("first_ls_no_release", int'(wrReady), 0);
    step();
    for (int i = 0; i < 4; i++) pix(3'd1);
    exp_ur_q.push_back(1'b0);
    lineStart = 1'b1;
    step();
    lineStart = 1'b0;
    @(negedge clk);
    chk("release_wrReady", int'(wrReady), 1);
    step();
    for (int i = 0; i < 4; i++) pix(3'd2);
    write_line(LP, 1'b0, 3'd3, 1'b0);
    line_start(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) pix(3'd3);

    // Line closing in the same cycle as lineStart is used one line later.
    write_line(3, 1'b0, 3'd5, 1'b0);
    wrValid = 1'b1; wrColor = 3'd5; wrLast = 1'b1;
    @(negedge clk);
    chk("close_ls_wrReady", int'(wrReady), 1);
    exp_ur_q.push_back(1'b1);
    lineStart = 1'b1;
    step();
    wrValid = 1'b0; wrLast = 1'b0; lineStart = 1'b0;
    step();
    for (int i = 0; i < 3; i++) pix('0);
    line_start(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) pix((i < 4) ? 3'd5 : 3'd0);

`ifdef LINE_BUFFER_STATS_EN
    // Statistics: 3 underruns, then 2 good swaps.
    do_reset();
    for (int i = 0; i < 3; i++) line_start(1'b1, 1'b0);
    write_line(4, 1'b0, 3'd4, 1'b1);
    line_start(1'b0, 1'b0);
    write_line(4, 1'b0, 3'd7, 1'b1);
    line_start(1'b0, 1'b0);
    @(negedge clk);
    chk("underrunCount", int'(underrunCount), 3);
    chk("lineCount", int'(lineCount), 2);
    step();
    pix(3'd7);
    pix(3'd7);
`endif

    // Mid-line reset discards everything.
    do_reset();
    line_start(1'b1, 1'b0);
    pix('0);

    repeat (3) step();
    chk("sb_pix_empty", exp_pix_q.size(), 0);
    chk("sb_ur_empty", exp_ur_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
